sid_table_loader: RTL
=====================

# sid_table_loader

Runtime writer for the SID combined-waveform lookup tables. It accepts a run-length-encoded byte stream from the host and fills a 2048×8 table RAM. It also serves the voice's table read port with the same 12-bit `wave` in, registered 8-bit `out` behaviour as the fixed tables. This lets any combined waveform (P&T, PS, ST, PST) be loaded at run time instead of baked into ROM init.

## Interface
- `ADDR_W`, 11: table address width; depth is 2**ADDR_W.
- `DATA_W`, 8: table entry width.
- `clock` input 1: sole clock.
- `reset_n` input 1: synchronous, active-low reset.
- `start` input 1: single-cycle pulse that begins a new table load.
- `in_data` input 8: record byte stream.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts the byte; a transfer happens when `in_valid && in_ready`.
- `wave` input 12: oscillator waveform value; the table is indexed by `wave[11:1]`.
- `out` output 8: registered table entry.
- `loading` output 1: a load is in progress.
- `done` output 1: the full table has been written since the last `start`.
- `checksum` output 8: present only with `SID_TABLE_CHECKSUM_EN`.

## Operation
- Each record is 3 bytes:
  - B0 = `{4'b0, end[11:8]}`
  - B1 = `end[7:0]`
  - B2 = `value`
- A record sets entries `[cur, end)` to `value`. `end` is exclusive and is clamped to 2048. `cur` is a 12-bit write pointer.
- B0 bits [7:4] are ignored.
- States and transitions:
  - IDLE → B0 on `start`.
  - B0 → B1 → B2 on each accepted byte.
  - B2 → FILL on accept if `end > cur`. Otherwise → B0, a zero-length record with no write.
  - FILL writes `RAM[cur] = value` and does `cur++` every cycle.
  - When `cur + 1 == end`, FILL goes to DONE if `end == 2048`, else to B0.
  - DONE → B0 on `start`.
- `start` in any state: `cur` = 0, `done` = 0, checksum cleared, state B0. Any partial record is discarded and a `start` during FILL aborts the fill.
- `in_ready` = 1 only in B0, B1 and B2. It is 0 in IDLE, FILL and DONE.
- `loading` = 1 in states B0, B1, B2 and FILL. `done` = 1 in DONE.
- The read port is independent of the load: `out <= RAM[wave[11:1]]` every cycle. During a load it returns current, possibly partial, contents.
- A read and a write to the same address in the same cycle return the old data (read-first).
- The RAM has no reset. Its contents are undefined until the first complete load.

## Timing
- Reset values: `out` = 0, `in_ready` = 0, `loading` = 0, `done` = 0, `checksum` = 0, `cur` = 0, state IDLE. Reset asserted mid-load aborts to IDLE and leaves RAM contents untouched.
- Read latency is 1 clock, from `wave` to `out`.
- Record timing:
  - B2 accepted at cycle t gives the first write at t+1 and the last write at t+N.
  - `in_ready` reasserts at t+N+1.
  - A zero-length record gives `in_ready` high again at t+1.
- Back-to-back bytes with `in_valid` held high are accepted one per cycle in B0, B1 and B2.
- A full table loaded as one record takes 3 + 2048 cycles from the first B0 accept to `done`.

## Configuration
- `SID_TABLE_CHECKSUM_EN` defined:
  - `checksum` is the 8-bit wrapping sum of every `value` written (one add per FILL cycle).
  - It is cleared on `start` and on reset.
  - It is valid when `done` = 1.
- Undefined: the `checksum` port and adder are absent and all other behaviour is identical.

## Structure
- Package `sid_pkg` holds:
  - the loader state enum (IDLE, B0, B1, B2, FILL, DONE);
  - `SID_TABLE_DEPTH` = 2048;
  - the record byte-count constant.
- Sub-module `sid_table_ram`: simple dual-port 2048×8 RAM with one write port, a registered read-first read port and no reset. The top holds the state machine, pointer, clamp logic and checksum.

## Test plan
- Reset, then `wave` = 0x000 → `out` = 0x00; `in_ready` = 0, `loading` = 0, `done` = 0.
- `start`, then one record {0x08, 0x00, 0x5A} → exactly 2048 write cycles, then `done` = 1. Every `wave[11:1]` reads 0x5A one cycle later. With the macro, `checksum` = 0x00 (2048×0x5A mod 256).
- Records {0x00, 0xFF, 0x00}, {0x01, 0x00, 0x07}, {0x08, 0x00, 0x00} → addr 0x0FE = 0x00, addr 0x0FF = 0x07, addr 0x100 = 0x00, `done` = 1.
- Zero-length and clamp case: {0x00, 0x10, 0x11}, then {0x00, 0x05, 0x22}, then {0x0F, 0xFF, 0x33} → the second record causes no write and `in_ready` returns after 1 cycle. The third clamps to 2048: addr 0x00F = 0x11, addr 0x010 = 0x33, `done` = 1.
- `start` mid-FILL, and separately `reset_n` = 0 mid-FILL → writes stop within 1 cycle.
  - After `start`: state B0, `cur` = 0, `done` = 0.
  - After reset: IDLE, and previously written entries still read back unchanged.
- Read during FILL at the address being written → `out` shows the old value; the next read shows the new value.

Source files
------------

// File: rtl/sid_pkg.sv
// Shared types and constants for the SID combined-waveform table loader.
package sid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B0   = 3'd1,
    ST_B1   = 3'd2,
    ST_B2   = 3'd3,
    ST_FILL = 3'd4,
    ST_DONE = 3'd5
  } sid_state_e;

  localparam int SID_TABLE_DEPTH = 2048;
  localparam int SID_REC_BYTES   = 3;

endpackage

// File: rtl/sid_table_ram.sv
// Simple dual-port table RAM: one write port, registered read-first read port.
// Only the read register is reset; the array itself has no reset.
module sid_table_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // Table write port
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read; nonblocking update of mem_r makes a same-cycle read see old data
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_data <= {DATA_W{1'b0}};
    end else begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/sid_table_loader.sv
// Run-length-encoded loader for the SID combined-waveform table plus its read port.
// Optional feature macro: SID_TABLE_CHECKSUM_EN adds the 8-bit checksum output.
module sid_table_loader
  import sid_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [11:0]       wave,
  output logic [DATA_W-1:0] out,
  output logic              loading,
  output logic              done
`ifdef SID_TABLE_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(SID_TABLE_DEPTH);

  sid_state_e        state_r, state_next_s;
  logic [ADDR_W:0]   cur_r, end_r, cur_inc_s, end_raw_s;
  logic [3:0]        end_hi_r;
  logic [DATA_W-1:0] value_r;
  logic              in_ready_r, loading_r, done_r;
  logic              accept_s, we_s, unused_s;

  assign accept_s  = in_valid && in_ready_r;
  assign cur_inc_s = cur_r + {{ADDR_W{1'b0}}, 1'b1};
  assign end_raw_s = {end_hi_r, in_data};
  // Writes are suppressed in the very cycle a restart or reset is sampled
  assign we_s      = (state_r == ST_FILL) && !start && reset_n;
  assign unused_s  = ^{wave[0], in_data[7:4]};

  assign in_ready  = in_ready_r;
  assign loading   = loading_r;
  assign done      = done_r;

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    if (start) begin
      state_next_s = ST_B0;
    end else begin
      case (state_r)
        ST_IDLE: state_next_s = ST_IDLE;
        ST_B0:   state_next_s = accept_s ? ST_B1 : ST_B0;
        ST_B1:   state_next_s = accept_s ? ST_B2 : ST_B1;
        ST_B2: begin
          if (accept_s && (end_r > cur_r)) begin
            state_next_s = ST_FILL;
          end else if (accept_s) begin
            state_next_s = ST_B0;
          end else begin
            state_next_s = ST_B2;
          end
        end
        ST_FILL: begin
          if (cur_inc_s == end_r) begin
            state_next_s = (end_r == DEPTH_C) ? ST_DONE : ST_B0;
          end else begin
            state_next_s = ST_FILL;
          end
        end
        ST_DONE: state_next_s = ST_DONE;
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // State register and registered status outputs decoded from the next state
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b0;
      loading_r  <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      in_ready_r <= (state_next_s == ST_B0) || (state_next_s == ST_B1) ||
                    (state_next_s == ST_B2);
      loading_r  <= (state_next_s == ST_B0) || (state_next_s == ST_B1) ||
                    (state_next_s == ST_B2) || (state_next_s == ST_FILL);
      done_r     <= (state_next_s == ST_DONE);
    end
  end

  // Write pointer and record fields; end is clamped to the table depth as B1 lands
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cur_r    <= {(ADDR_W + 1){1'b0}};
      end_r    <= {(ADDR_W + 1){1'b0}};
      end_hi_r <= 4'h0;
      value_r  <= {DATA_W{1'b0}};
    end else begin
      if (start) begin
        cur_r <= {(ADDR_W + 1){1'b0}};
      end else if (we_s) begin
        cur_r <= cur_inc_s;
      end
      if (accept_s && (state_r == ST_B0)) begin
        end_hi_r <= in_data[3:0];
      end
      if (accept_s && (state_r == ST_B1)) begin
        end_r <= (end_raw_s > DEPTH_C) ? DEPTH_C : end_raw_s;
      end
      if (accept_s && (state_r == ST_B2)) begin
        value_r <= in_data;
      end
    end
  end

`ifdef SID_TABLE_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_r;

  // Wrapping sum of every value written since the last start
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      checksum_r <= {DATA_W{1'b0}};
    end else if (start) begin
      checksum_r <= {DATA_W{1'b0}};
    end else if (we_s) begin
      checksum_r <= checksum_r + value_r;
    end
  end

  assign checksum = checksum_r;
`endif

  sid_table_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (we_s),
    .wr_addr (cur_r[ADDR_W-1:0]),
    .wr_data (value_r),
    .rd_addr (wave[ADDR_W:1]),
    .rd_data (out)
  );

endmodule
